// File: rtl/div8_pkg.sv
`default_nettype none
// =============================================================
// div8_pkg - shared constants for the restoring divider
// Rev 1.0
// =============================================================
package div8_pkg;

  localparam int c_DEF_WIDTH = 8;

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_RUN  = 2'd1;
  localparam logic [1:0] c_ST_DONE = 2'd2;

  localparam int                     c_CNT_W    = $clog2(c_DEF_WIDTH + 1);
  localparam logic [c_DEF_WIDTH-1:0] c_DBZ_QUOT = {c_DEF_WIDTH{1'b1}};

  function automatic int f_cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/div8_restoring_if.sv
`default_nettype none
// =============================================================
// div8_restoring_if - start/busy/done handshake and operand bus
// Rev 1.0
// =============================================================
interface div8_restoring_if #(
  parameter int WIDTH = div8_pkg::c_DEF_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             dbz;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, dbz
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, dbz
  );
endinterface
`default_nettype wire

// File: rtl/div8_restoring_sub_borrow.sv
`default_nettype none
// =============================================================
// sub_borrow - ripple-borrow subtractor built from full-subtractor cells
// Rev 1.0
// =============================================================
module sub_borrow #(
  parameter int WIDTH = 9
) (
  input  wire logic [WIDTH-1:0] i_a,
  input  wire logic [WIDTH-1:0] i_b,
  output logic      [WIDTH-1:0] o_diff,
  output logic                  o_borrow
);

  logic [WIDTH:0] w_bin;

  assign w_bin[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign o_diff[i]  = i_a[i] ^ i_b[i] ^ w_bin[i];
    assign w_bin[i+1] = (~i_a[i] & i_b[i]) | (~(i_a[i] ^ i_b[i]) & w_bin[i]);
  end

  assign o_borrow = w_bin[WIDTH];

endmodule
`default_nettype wire

// File: rtl/div8_restoring.sv
`default_nettype none
// =============================================================
// div8_restoring - sequential unsigned restoring divider, 1 quotient bit/clk
// Rev 1.0
// =============================================================
module div8_restoring
  import div8_pkg::*;
#(
  parameter int WIDTH = c_DEF_WIDTH
) (
  input wire logic         clk,
  input wire logic         rst,
  div8_restoring_if.slave  bus
);

  localparam int                 c_CW   = f_cnt_w(WIDTH);
  localparam logic [c_CW-1:0]    c_LAST = c_CW'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_div;
  logic [c_CW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_remo;
  logic             r_dbz;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic             w_borrow;
  logic [WIDTH:0]   w_rem_nxt;
  logic [WIDTH-1:0] w_q_nxt;

  // The remainder never exceeds the divisor, so its MSB shifts out harmlessly.
  assign w_shift = (r_rem << 1) | (WIDTH+1)'(r_q[WIDTH-1]);

  sub_borrow #(.WIDTH(WIDTH + 1)) u_sub (
    .i_a      (w_shift),
    .i_b      ({1'b0, r_div}),
    .o_diff   (w_trial),
    .o_borrow (w_borrow)
  );

  assign w_rem_nxt = w_borrow ? w_shift : w_trial;
  assign w_q_nxt   = {r_q[WIDTH-2:0], ~w_borrow};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_ST_IDLE;
      r_rem   <= '0;
      r_q     <= '0;
      r_div   <= '0;
      r_cnt   <= '0;
      r_quot  <= '0;
      r_remo  <= '0;
      r_dbz   <= 1'b0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (bus.start) begin
            r_q   <= bus.dividend;
            r_div <= bus.divisor;
            r_rem <= '0;
            r_cnt <= '0;
            if (bus.divisor == '0) begin
              r_state <= c_ST_DONE;
              r_dbz   <= 1'b1;
              r_quot  <= '1;
              r_remo  <= bus.dividend;
            end else begin
              r_state <= c_ST_RUN;
            end
          end
        end
        c_ST_RUN: begin
          r_rem <= w_rem_nxt;
          r_q   <= w_q_nxt;
          r_cnt <= r_cnt + 1'b1;
          // Results are loaded on the same edge that enters DONE.
          if (r_cnt == c_LAST) begin
            r_state <= c_ST_DONE;
            r_quot  <= w_q_nxt;
            r_remo  <= w_rem_nxt[WIDTH-1:0];
            r_dbz   <= 1'b0;
          end
        end
        c_ST_DONE: r_state <= c_ST_IDLE;
        default:   r_state <= c_ST_IDLE;
      endcase
    end
  end

  assign bus.busy      = (r_state != c_ST_IDLE);
  assign bus.done      = (r_state == c_ST_DONE);
  assign bus.quotient  = r_quot;
  assign bus.remainder = r_remo;
  assign bus.dbz       = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_div8_restoring.sv
`default_nettype none
// =============================================================
// tb_div8_restoring - directed and sweep checks for div8_restoring
// Rev 1.0
// =============================================================
module tb_div8_restoring;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  div8_restoring_if #(.WIDTH(8)) bus ();

  div8_restoring #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; start is sampled on the following posedge (cycle 0).
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int lat,
                        input logic [7:0] eq, input logic [7:0] er, input logic edbz,
                        input bit full);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    for (int c = 1; c <= lat + 1; c++) begin
      @(negedge clk);
      bus.start    = 1'b0;
      bus.dividend = 8'($urandom);
      bus.divisor  = 8'($urandom);
      if (full) begin
        check($sformatf("busy_c%0d", c), 32'(bus.busy), 32'(c <= lat));
        check($sformatf("done_c%0d", c), 32'(bus.done), 32'(c == lat));
      end
      if (c == lat) begin
        check($sformatf("quot_%0d/%0d", a, b), 32'(bus.quotient), 32'(eq));
        check($sformatf("rem_%0d/%0d", a, b), 32'(bus.remainder), 32'(er));
        check($sformatf("dbz_%0d/%0d", a, b), 32'(bus.dbz), 32'(edbz));
      end
    end
  endtask

  task automatic run_model(input logic [7:0] a, input logic [7:0] b);
    if (b == 8'd0) run_op(a, b, 1, 8'hFF, a, 1'b1, 1'b0);
    else           run_op(a, b, 9, a / b, a % b, 1'b0, 1'b0);
  endtask

  initial begin
    int         dones;
    logic [7:0] ra, rb;

    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = 8'd0;
    bus.divisor  = 8'd0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_quot", 32'(bus.quotient), 32'd0);
    check("rst_rem",  32'(bus.remainder), 32'd0);
    check("rst_dbz",  32'(bus.dbz), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(8'd200, 8'd7,  9, 8'd28,  8'd4, 1'b0, 1'b1);
    run_op(8'd255, 8'd1,  9, 8'd255, 8'd0, 1'b0, 1'b1);
    run_op(8'd5,   8'd9,  9, 8'd0,   8'd5, 1'b0, 1'b1);
    run_op(8'd100, 8'd0,  1, 8'hFF,  8'd100, 1'b1, 1'b1);
    run_op(8'd100, 8'd10, 9, 8'd10,  8'd0, 1'b0, 1'b1);

    // Asynchronous reset in the middle of RUN.
    bus.start = 1'b1; bus.dividend = 8'd200; bus.divisor = 8'd7;
    repeat (4) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_done", 32'(bus.done), 32'd0);
    check("mid_rst_quot", 32'(bus.quotient), 32'd0);
    check("mid_rst_rem",  32'(bus.remainder), 32'd0);
    check("mid_rst_dbz",  32'(bus.dbz), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_idle", 32'(bus.busy), 32'd0);
    run_op(8'd77, 8'd3, 9, 8'd25, 8'd2, 1'b0, 1'b1);

    // Extra starts during RUN and in the DONE cycle must be dropped.
    dones = 0;
    bus.start = 1'b1; bus.dividend = 8'd50; bus.divisor = 8'd5;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (bus.done) dones++;
      if (c == 9) begin
        check("ign_quot", 32'(bus.quotient), 32'd10);
        check("ign_rem",  32'(bus.remainder), 32'd0);
      end
      if (c >= 10) check($sformatf("ign_idle_c%0d", c), 32'(bus.busy), 32'd0);
      bus.start    = (c == 3 || c == 9);
      bus.dividend = 8'd9;
      bus.divisor  = 8'd2;
    end
    bus.start = 1'b0;
    check("ign_done_pulses", 32'(dones), 32'd1);

    // Corner operands followed by a random sweep, divisor 0 forced regularly.
    run_model(8'd0,   8'd255);
    run_model(8'd255, 8'd255);
    run_model(8'd0,   8'd0);
    run_model(8'd128, 8'd128);
    run_model(8'd254, 8'd255);
    run_model(8'd255, 8'd2);
    run_model(8'd255, 8'd0);
    for (int i = 0; i < 1500; i++) begin
      ra = 8'($urandom);
      rb = (i % 16 == 0) ? 8'd0 : 8'($urandom);
      run_model(ra, rb);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
